// File: rtl/adv_video_pkg.sv
// adv_video_pkg: config-word bit offsets and unpacked video timing fields shared by the output backend.
package adv_video_pkg;
  localparam int H_TOTAL_LSB = 0;
  localparam int H_ACTIVE_LSB = 12;
  localparam int H_SYNCLEN_LSB = 24;
  localparam int H_BACKPORCH_LSB = 0;
  localparam int V_TOTAL_LSB = 9;
  localparam int INTERLACED_BIT = 20;
  localparam int V_BACKPORCH_LSB = 21;
  localparam int V_ACTIVE_LSB = 0;
  localparam int V_SYNCLEN_LSB = 12;
  localparam int V_STARTLINE_LSB = 16;
  typedef struct packed {
    logic [11:0] h_total;
    logic [11:0] h_active;
    logic [7:0]  h_synclen;
    logic [8:0]  h_backporch;
    logic [10:0] v_total;
    logic [10:0] v_active;
    logic [3:0]  v_synclen;
    logic [8:0]  v_backporch;
    logic [10:0] v_startline;
    logic        interlaced;
  } timing_t;
  function automatic timing_t unpack_timing(input logic [31:0] c1, input logic [31:0] c2, input logic [31:0] c3);
    timing_t t;
    t.h_total = c1[H_TOTAL_LSB +: 12];
    t.h_active = c1[H_ACTIVE_LSB +: 12];
    t.h_synclen = c1[H_SYNCLEN_LSB +: 8];
    t.h_backporch = c2[H_BACKPORCH_LSB +: 9];
    t.v_total = c2[V_TOTAL_LSB +: 11];
    t.interlaced = c2[INTERLACED_BIT];
    t.v_backporch = c2[V_BACKPORCH_LSB +: 9];
    t.v_active = c3[V_ACTIVE_LSB +: 11];
    t.v_synclen = c3[V_SYNCLEN_LSB +: 4];
    t.v_startline = c3[V_STARTLINE_LSB +: 11];
    return t;
  endfunction
endpackage

// File: rtl/video_sync_delay.sv
// video_sync_delay: fixed-depth shift register for {hsync_n, vsync_n, de}; every stage resets to the inactive pattern.
module video_sync_delay #(
  parameter int         DEPTH   = 3,
  parameter logic [2:0] RST_VAL = 3'b110
) (
  input  logic       PCLK_i,
  input  logic       reset,
  input  logic [2:0] d,
  output logic [2:0] q
);
  logic [2:0] sr [DEPTH];
  always_ff @(posedge PCLK_i or posedge reset)
    if (reset)
      for (int i = 0; i < DEPTH; i++) sr[i] <= RST_VAL;
    else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  assign q = sr[DEPTH-1];
endmodule

// File: rtl/adv7513_backend.sv
// adv7513_backend: ADV7513 timing generator issuing pixel fetches and re-aligning returned RGB with syncs/DE.
module adv7513_backend
  import adv_video_pkg::*;
#(
  parameter int PIXEL_LATENCY = 2
) (
  input  logic        PCLK_i,
  input  logic        reset,
  input  logic [31:0] hv_out_config,
  input  logic [31:0] hv_out_config2,
  input  logic [31:0] hv_out_config3,
  input  logic        lock_en_i,
  input  logic        frame_lock_i,
  input  logic [7:0]  R_i,
  input  logic [7:0]  G_i,
  input  logic [7:0]  B_i,
  output logic [7:0]  R_o,
  output logic [7:0]  G_o,
  output logic [7:0]  B_o,
  output logic        HSYNC_o,
  output logic        VSYNC_o,
  output logic        DE_o,
  output logic        FID_o,
  output logic        fetch_o,
  output logic [10:0] xpos_o,
  output logic [10:0] ypos_o
);
  timing_t t;
  logic [11:0] h_cnt, h_half;
  logic [10:0] v_cnt, v_sl;
  logic fid, h_wrap, v_wrap, hsync_n, vsync_n, de, vs_odd, vs_even;
  logic [12:0] h_start, h_end, v_start, v_end, x_off, y_off;
  logic [2:0] dq;
  logic unused_bits;
  assign t = unpack_timing(hv_out_config, hv_out_config2, hv_out_config3);
  assign unused_bits = ^{hv_out_config2[31:30], hv_out_config3[31:27], hv_out_config3[11], x_off[12:11], y_off[12:11]};
  // wrap uses >= so a shrunk total pulls an overshooting counter back immediately
  assign h_wrap = {1'b0, h_cnt} + 13'd1 >= {1'b0, t.h_total};
  assign v_wrap = {2'b0, v_cnt} + 13'd1 >= {2'b0, t.v_total} + {12'd0, t.interlaced & fid};
  assign h_start = {5'd0, t.h_synclen} + {4'd0, t.h_backporch};
  assign h_end = h_start + {1'b0, t.h_active};
  assign v_start = {9'd0, t.v_synclen} + {4'd0, t.v_backporch};
  assign v_end = v_start + {2'b0, t.v_active};
  assign x_off = {1'b0, h_cnt} - h_start;
  assign y_off = {2'b0, v_cnt} - v_start;
  assign h_half = t.h_total >> 1;
  assign v_sl = {7'd0, t.v_synclen};
  assign hsync_n = h_cnt >= {4'd0, t.h_synclen};
  assign vs_odd = v_cnt < v_sl;
  // even field: vsync spans the same lines shifted by half a line
  assign vs_even = (vs_odd && (v_cnt != 11'd0 || h_cnt >= h_half)) || (v_cnt == v_sl && v_sl != 11'd0 && h_cnt < h_half);
  assign vsync_n = !((t.interlaced && !fid) ? vs_even : vs_odd);
  assign de = {1'b0, h_cnt} >= h_start && {1'b0, h_cnt} < h_end && {2'b0, v_cnt} >= v_start && {2'b0, v_cnt} < v_end;
  assign FID_o = fid;
  always_ff @(posedge PCLK_i or posedge reset)
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
      fid <= 1'b0;
    end else if (lock_en_i && frame_lock_i) begin
      h_cnt <= '0;
      v_cnt <= t.v_startline;
      fid <= t.interlaced;
    end else if (h_wrap) begin
      h_cnt <= '0;
      v_cnt <= v_wrap ? '0 : v_cnt + 11'd1;
      if (v_wrap) fid <= t.interlaced & ~fid;
    end else
      h_cnt <= h_cnt + 12'd1;
  always_ff @(posedge PCLK_i or posedge reset)
    if (reset) begin
      fetch_o <= 1'b0;
      xpos_o <= '0;
      ypos_o <= '0;
    end else begin
      fetch_o <= de;
      if (de) begin
        xpos_o <= x_off[10:0];
        ypos_o <= y_off[10:0];
      end
    end
  video_sync_delay #(.DEPTH(PIXEL_LATENCY + 1)) u_delay (
    .PCLK_i(PCLK_i),
    .reset(reset),
    .d({hsync_n, vsync_n, de}),
    .q(dq)
  );
  always_ff @(posedge PCLK_i or posedge reset)
    if (reset) begin
      HSYNC_o <= 1'b1;
      VSYNC_o <= 1'b1;
      DE_o <= 1'b0;
      R_o <= '0;
      G_o <= '0;
      B_o <= '0;
    end else begin
      {HSYNC_o, VSYNC_o, DE_o} <= dq;
      R_o <= dq[0] ? R_i : 8'd0;
      G_o <= dq[0] ? G_i : 8'd0;
      B_o <= dq[0] ? B_i : 8'd0;
    end
endmodule

// File: tb/tb_adv7513_backend.sv
// tb_adv7513_backend: frame statistics on small modes from a vector table, plus directed 640x480 / 480i /
// frame-lock / reset / reprogramming sequences. Upstream returns R = xpos[7:0] two cycles after the fetch.
module tb_adv7513_backend;
  logic PCLK_i = 1'b0;
  logic reset = 1'b1;
  logic [31:0] hv_out_config, hv_out_config2, hv_out_config3;
  logic lock_en_i = 1'b0, frame_lock_i = 1'b0;
  logic [7:0] R_i = '0, G_i = '0, B_i = 8'h5A;
  logic [7:0] R_o, G_o, B_o;
  logic HSYNC_o, VSYNC_o, DE_o, FID_o, fetch_o;
  logic [10:0] xpos_o, ypos_o;
  logic [7:0] xq1 = '0, xq2 = '0;
  int tests = 0, fails = 0;
  typedef struct {
    int ht, ha, hs, hbp, vt, va, vs, vbp;
    int exp_hs, exp_vs, exp_de, exp_fr;
  } vec_t;
  vec_t vecs[3];
  adv7513_backend #(.PIXEL_LATENCY(2)) dut (
    .PCLK_i(PCLK_i), .reset(reset),
    .hv_out_config(hv_out_config), .hv_out_config2(hv_out_config2), .hv_out_config3(hv_out_config3),
    .lock_en_i(lock_en_i), .frame_lock_i(frame_lock_i),
    .R_i(R_i), .G_i(G_i), .B_i(B_i), .R_o(R_o), .G_o(G_o), .B_o(B_o),
    .HSYNC_o(HSYNC_o), .VSYNC_o(VSYNC_o), .DE_o(DE_o), .FID_o(FID_o),
    .fetch_o(fetch_o), .xpos_o(xpos_o), .ypos_o(ypos_o)
  );
  always #5 PCLK_i = ~PCLK_i;
  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge PCLK_i);
    @(negedge PCLK_i);
    R_i = xq2;
    G_i = ~xq2;
    xq2 = xq1;
    xq1 = xpos_o[7:0];
  endtask
  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask
  task automatic pulse();
    frame_lock_i = 1'b1;
    step();
    frame_lock_i = 1'b0;
  endtask
  task automatic set_cfg(input int ht, ha, hs, hbp, vt, va, vs, vbp, vsl, il);
    hv_out_config = {8'(hs), 12'(ha), 12'(ht)};
    hv_out_config2 = {2'b0, 9'(vbp), 1'(il), 11'(vt), 9'(hbp)};
    hv_out_config3 = {5'b0, 11'(vsl), 4'(vs), 1'b0, 11'(va)};
  endtask
  task automatic wait_hv(input int v, input int h, input string nm);
    int n = 0;
    while (!(int'(dut.v_cnt) == v && int'(dut.h_cnt) == h) && n < 5000) begin
      step();
      n++;
    end
    chk(nm, int'(n < 5000), 1);
  endtask
  initial begin
    int hs, vs, de, fc, bad, fr, dr, fidc, n, r_first, r_last, g_last;
    vecs[0] = '{40, 24, 4, 6, 20, 10, 2, 3, 80, 80, 240, 211};
    vecs[1] = '{32, 16, 3, 5, 16, 8, 1, 2, 48, 32, 128, 105};
    vecs[2] = '{50, 30, 8, 4, 12, 6, 3, 1, 96, 150, 180, 213};
    for (int k = 0; k < 3; k++) begin
      set_cfg(vecs[k].ht, vecs[k].ha, vecs[k].hs, vecs[k].hbp, vecs[k].vt, vecs[k].va, vecs[k].vs, vecs[k].vbp, 0, 0);
      do_reset();
      if (k == 0) begin
        chk("reset HSYNC_o", int'(HSYNC_o), 1);
        chk("reset DE_o", int'(DE_o), 0);
      end
      hs = 0; vs = 0; de = 0; fc = 0; bad = 0; fr = -1; dr = -1; fidc = 0;
      for (int j = 1; j <= vecs[k].ht * vecs[k].vt; j++) begin
        step();
        if (!HSYNC_o) hs++;
        if (!VSYNC_o) vs++;
        if (DE_o) de++;
        if (fetch_o) fc++;
        if (FID_o) fidc++;
        if (!DE_o && {R_o, G_o, B_o} != 24'd0) bad++;
        if (fetch_o && fr < 0) fr = j;
        if (DE_o && dr < 0) dr = j;
      end
      chk($sformatf("v%0d hsync_low", k), hs, vecs[k].exp_hs);
      chk($sformatf("v%0d vsync_low", k), vs, vecs[k].exp_vs);
      chk($sformatf("v%0d de_cycles", k), de, vecs[k].exp_de);
      chk($sformatf("v%0d fetch_cycles", k), fc, vecs[k].exp_de);
      chk($sformatf("v%0d fetch_rise", k), fr, vecs[k].exp_fr);
      chk($sformatf("v%0d de_after_fetch", k), dr - fr, 3);
      chk($sformatf("v%0d rgb_outside_de", k), bad, 0);
      chk($sformatf("v%0d fid_progressive", k), fidc, 0);
    end
    // 640x480p60: first three lines after reset
    set_cfg(800, 640, 96, 48, 525, 480, 2, 33, 35, 0);
    do_reset();
    hs = 0; vs = 0; de = 0;
    for (int j = 1; j <= 2400; j++) begin
      step();
      if (!HSYNC_o) hs++;
      if (!VSYNC_o) vs++;
      if (DE_o) de++;
    end
    chk("640 hsync_low_3lines", hs, 288);
    chk("640 vsync_low", vs, 1600);
    chk("640 de_in_sync", de, 0);
    // jump to the first active line and check pixel alignment across it
    lock_en_i = 1'b1;
    pulse();
    chk("640 lock v", int'(dut.v_cnt), 35);
    chk("640 lock h", int'(dut.h_cnt), 0);
    de = 0; bad = 0; fr = -1; dr = -1; r_first = -1; r_last = -1; g_last = -1;
    for (int j = 1; j <= 804; j++) begin
      step();
      if (fetch_o && fr < 0) fr = j;
      if (DE_o && dr < 0) begin
        dr = j;
        r_first = int'(R_o);
      end
      if (DE_o) begin
        de++;
        r_last = int'(R_o);
        g_last = int'(G_o);
      end
      if (!DE_o && {R_o, G_o, B_o} != 24'd0) bad++;
    end
    chk("640 de_per_line", de, 640);
    chk("640 de_after_fetch", dr - fr, 3);
    chk("640 R first", r_first, 8'h00);
    chk("640 R last", r_last, 8'h7F);
    chk("640 G last", g_last, 8'h80);
    chk("640 rgb_outside_de", bad, 0);
    // asynchronous reset in the middle of an active line
    n = 0;
    while (!DE_o && n < 1000) begin
      step();
      n++;
    end
    chk("mid-line DE reached", int'(n < 1000), 1);
    for (int j = 0; j < 100; j++) step();
    #2 reset = 1'b1;
    #1;
    chk("async HSYNC_o", int'(HSYNC_o), 1);
    chk("async VSYNC_o", int'(VSYNC_o), 1);
    chk("async DE_o", int'(DE_o), 0);
    chk("async fetch_o", int'(fetch_o), 0);
    chk("async xpos_o", int'(xpos_o), 0);
    chk("async ypos_o", int'(ypos_o), 0);
    chk("async R_o", int'(R_o), 0);
    chk("async h_cnt", int'(dut.h_cnt), 0);
    chk("async v_cnt", int'(dut.v_cnt), 35 * 0);
    @(negedge PCLK_i);
    reset = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (HSYNC_o && n < 20);
    chk("hsync after release", n, 4);
    // H_TOTAL shrunk below the running count
    do_reset();
    for (int j = 0; j < 600; j++) step();
    chk("pre-shrink h", int'(dut.h_cnt), 600);
    set_cfg(400, 640, 96, 48, 525, 480, 2, 33, 35, 0);
    step();
    chk("shrink h wrap", int'(dut.h_cnt), 0);
    chk("shrink v inc", int'(dut.v_cnt), 1);
    for (int j = 0; j < 400; j++) step();
    chk("shrink next wrap h", int'(dut.h_cnt), 0);
    chk("shrink next wrap v", int'(dut.v_cnt), 2);
    // frame lock: mid-line, on an h wrap, and ignored when disabled
    set_cfg(800, 640, 96, 48, 525, 480, 2, 33, 300, 0);
    do_reset();
    lock_en_i = 1'b1;
    for (int j = 0; j < 5; j++) step();
    pulse();
    chk("lock to 300", int'(dut.v_cnt), 300);
    set_cfg(800, 640, 96, 48, 525, 480, 2, 33, 10, 0);
    for (int j = 0; j < 5; j++) step();
    pulse();
    chk("lock mid v", int'(dut.v_cnt), 10);
    chk("lock mid h", int'(dut.h_cnt), 0);
    wait_hv(10, 799, "reach h wrap");
    pulse();
    chk("lock at wrap v", int'(dut.v_cnt), 10);
    chk("lock at wrap h", int'(dut.h_cnt), 0);
    lock_en_i = 1'b0;
    for (int j = 0; j < 3; j++) step();
    pulse();
    chk("lock disabled h", int'(dut.h_cnt), 4);
    chk("lock disabled v", int'(dut.v_cnt), 10);
    // 480i: even field first, half-line vsync, then 262/263 line fields
    set_cfg(800, 640, 96, 48, 262, 240, 3, 15, 10, 1);
    do_reset();
    n = 0;
    do begin
      step();
      n++;
    end while (VSYNC_o && n < 1000);
    chk("even vsync fall", n, 404);
    do begin
      step();
      n++;
    end while (!VSYNC_o && n < 4000);
    chk("even vsync rise", n, 2804);
    chk("even FID", int'(FID_o), 0);
    set_cfg(8, 640, 96, 48, 262, 240, 3, 15, 10, 1);
    wait_hv(261, 7, "even last line");
    step();
    chk("even wrap v", int'(dut.v_cnt), 0);
    chk("odd FID", int'(FID_o), 1);
    wait_hv(262, 7, "odd last line");
    step();
    chk("odd wrap v", int'(dut.v_cnt), 0);
    chk("back to even FID", int'(FID_o), 0);
    lock_en_i = 1'b1;
    pulse();
    chk("480i lock v", int'(dut.v_cnt), 10);
    chk("480i lock h", int'(dut.h_cnt), 0);
    chk("480i lock FID", int'(FID_o), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
